gen1_scramble_ctrl: RTL and testbench

Sequencer for the Gen1 scramble datapath on a x1 link carrying 4 symbols per clock, byte 0 transmitted first. It owns the 16-bit LFSR and walks it through four symbols per cycle, applying COM re-seeding and SKP hold. It detects TS1/TS2 ordered-set windows and emits registered, data-aligned symbols plus the four per-byte scramble values and masks for the combinational `gen1_scramble_data` stage.

---
 rtl/gen1_scramble_pkg.sv | 58 +++++
 rtl/gen1_scramble_ctrl_step.sv | 43 ++++
 rtl/gen1_scramble_ctrl.sv | 128 ++++++++++++
 tb/tb_gen1_scramble_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gen1_scramble_pkg.sv
// ---------------------------------------------------------------------------
// gen1_scramble_pkg
// Shared definitions for the Gen1 scramble sequencer. It holds the ordered-set
// symbol codes, the LFSR seed and feedback taps, the TS-window FSM state type,
// and the per-symbol TS-window step function.
// ---------------------------------------------------------------------------
package gen1_scramble_pkg;

  localparam logic [7:0]  COM        = 8'hBC;
  localparam logic [7:0]  SKP        = 8'h1C;
  localparam logic [7:0]  PAD        = 8'hF7;
  localparam logic [15:0] LFSR_SEED  = 16'hFFFF;
  // Feedback taps for x^16+x^5+x^4+x^3+1 (Galois form; the x^16 term is the
  // bit shifted out of position 15).
  localparam logic [15:0] LFSR_TAPS  = 16'h0039;
  localparam int          TS_LEN     = 16;

  typedef enum logic {TS_IDLE, TS_WIN} ts_state_e;

  typedef struct packed {
    ts_state_e  state;
    logic [3:0] cnt;
    logic       ts;
  } ts_step_t;

  // One symbol of the TS-window tracker. cnt counts the symbols that follow
  // the COM. The window closes on the symbol that brings cnt to TS_LEN-1, so
  // the 4-bit counter never wraps.
  function automatic ts_step_t ts_step(input ts_state_e  st,
                                       input logic [3:0] cnt,
                                       input logic [7:0] sym,
                                       input logic       is_k);
    ts_step_t r;
    r.state = st;
    r.cnt   = cnt;
    r.ts    = 1'b0;
    if (is_k && sym == COM) begin
      r.state = TS_WIN;
      r.cnt   = '0;
    end else if (st == TS_WIN) begin
      if (is_k && sym != PAD) begin
        // SKP/FTS/EIOS or any other K ends the window; this byte is not masked
        r.state = TS_IDLE;
        r.cnt   = '0;
      end else begin
        r.ts = 1'b1;
        if (cnt == 4'(TS_LEN - 2)) begin
          r.state = TS_IDLE;
          r.cnt   = '0;
        end else begin
          r.cnt = cnt + 4'd1;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/gen1_scramble_ctrl_step.sv
// ---------------------------------------------------------------------------
// gen1_lfsr_symbol_step
// Combinational one-symbol LFSR step. It produces the 8-bit keystream value
// for the current state and the state handed to the next symbol, with COM
// re-seeding and SKP hold applied.
// Ports:
//   lfsr_cur  in  16  state seen by this symbol
//   sym       in   8  symbol byte
//   is_k      in   1  K flag of the symbol
//   lfsr_nxt  out 16  state for the following symbol
//   value     out  8  keystream, [7] = first output bit (pairs with data bit 0)
// ---------------------------------------------------------------------------
module gen1_lfsr_symbol_step
  import gen1_scramble_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED
) (
  input  logic [15:0] lfsr_cur,
  input  logic [7:0]  sym,
  input  logic        is_k,
  output logic [15:0] lfsr_nxt,
  output logic [7:0]  value
);

  logic [15:0] adv;

  always_comb begin
    adv   = lfsr_cur;
    value = '0;
    for (int i = 0; i < 8; i++) begin
      value[7-i] = adv[15];
      adv = {adv[14:0], 1'b0} ^ (adv[15] ? LFSR_TAPS : 16'h0000);
    end
    if (is_k && sym == COM) begin
      lfsr_nxt = SEED;
    end else if (is_k && sym == SKP) begin
      lfsr_nxt = lfsr_cur;
    end else begin
      lfsr_nxt = adv;
    end
  end

endmodule

// File: rtl/gen1_scramble_ctrl.sv
// ---------------------------------------------------------------------------
// gen1_scramble_ctrl
// Sequencer for the Gen1 scramble datapath. It handles 4 symbols per clock,
// with byte 0 transmitted first. It walks the LFSR through the beat, tracks
// TS1/TS2 windows, and registers the data-aligned symbols, the per-byte
// keystream and the TS masks.
// Ports:
//   clk_i, rst_i                 clock, async active-high reset
//   valid_i, data_i, datak_i     input beat (byte n = data_i[8n+7:8n])
//   scramble_enable_i            0 = pass-through for this beat
//   valid_o, data_o, datak_o     registered beat
//   lfsr1..4_scramble_value_o    keystream for bytes 0..3
//   training_sequence_o          per-byte "inside TS window" mask
//   scramble_enable_o            registered scramble_enable_i
// ---------------------------------------------------------------------------
module gen1_scramble_ctrl
  import gen1_scramble_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [31:0] data_i,
  input  logic [3:0]  datak_i,
  input  logic        scramble_enable_i,
  output logic        valid_o,
  output logic [31:0] data_o,
  output logic [3:0]  datak_o,
  output logic [7:0]  lfsr1_scramble_value_o,
  output logic [7:0]  lfsr2_scramble_value_o,
  output logic [7:0]  lfsr3_scramble_value_o,
  output logic [7:0]  lfsr4_scramble_value_o,
  output logic [3:0]  training_sequence_o,
  output logic        scramble_enable_o
);

  logic [15:0] lfsr_st;
  ts_state_e   ts_state;
  logic [3:0]  ts_cnt;

  logic [15:0] chain [0:4];
  logic [7:0]  value [0:3];

  ts_state_e   ts_state_nxt;
  logic [3:0]  ts_cnt_nxt;
  logic [3:0]  ts_bits;
  ts_step_t    ts_r;

  logic        vld_p1;
  logic [31:0] data_p1;
  logic [3:0]  datak_p1;
  logic [7:0]  val_p1 [0:3];
  logic [3:0]  ts_p1;
  logic        en_p1;

  // ---- p0: four chained symbol steps on the current beat ----
  assign chain[0] = lfsr_st;

  for (genvar n = 0; n < 4; n++) begin : g_step
    gen1_lfsr_symbol_step #(.SEED(SEED)) u_step (
      .lfsr_cur (chain[n]),
      .sym      (data_i[8*n +: 8]),
      .is_k     (datak_i[n]),
      .lfsr_nxt (chain[n+1]),
      .value    (value[n])
    );
  end

  always_comb begin
    ts_state_nxt = ts_state;
    ts_cnt_nxt   = ts_cnt;
    ts_bits      = '0;
    ts_r         = '0;
    for (int n = 0; n < 4; n++) begin
      ts_r         = ts_step(ts_state_nxt, ts_cnt_nxt, data_i[8*n +: 8], datak_i[n]);
      ts_state_nxt = ts_r.state;
      ts_cnt_nxt   = ts_r.cnt;
      ts_bits[n]   = ts_r.ts;
    end
  end

  // Sequencer state advances only on a valid beat.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_st  <= SEED;
      ts_state <= TS_IDLE;
      ts_cnt   <= '0;
    end else if (valid_i) begin
      lfsr_st  <= chain[4];
      ts_state <= ts_state_nxt;
      ts_cnt   <= ts_cnt_nxt;
    end
  end

  // ---- p1: registered, data-aligned outputs ----
  // The payload holds its last value through stalls.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p1   <= 1'b0;
      data_p1  <= '0;
      datak_p1 <= '0;
      ts_p1    <= '0;
      en_p1    <= 1'b0;
      for (int n = 0; n < 4; n++) val_p1[n] <= '0;
    end else begin
      vld_p1 <= valid_i;
      if (valid_i) begin
        data_p1  <= data_i;
        datak_p1 <= datak_i;
        ts_p1    <= ts_bits;
        en_p1    <= scramble_enable_i;
        for (int n = 0; n < 4; n++) val_p1[n] <= value[n];
      end
    end
  end

  assign valid_o                = vld_p1;
  assign data_o                 = data_p1;
  assign datak_o                = datak_p1;
  assign lfsr1_scramble_value_o = val_p1[0];
  assign lfsr2_scramble_value_o = val_p1[1];
  assign lfsr3_scramble_value_o = val_p1[2];
  assign lfsr4_scramble_value_o = val_p1[3];
  assign training_sequence_o    = ts_p1;
  assign scramble_enable_o      = en_p1;

endmodule

// File: tb/tb_gen1_scramble_ctrl.sv
module tb_gen1_scramble_ctrl;

  localparam logic [7:0] S_COM = 8'hBC;
  localparam logic [7:0] S_SKP = 8'h1C;
  localparam logic [7:0] S_PAD = 8'hF7;
  localparam logic [7:0] S_FTS = 8'h3C;
  localparam logic [15:0] M_SEED = 16'hFFFF;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        valid_i = 1'b0;
  logic [31:0] data_i = '0;
  logic [3:0]  datak_i = '0;
  logic        scramble_enable_i = 1'b0;
  logic        valid_o;
  logic [31:0] data_o;
  logic [3:0]  datak_o;
  logic [7:0]  v1, v2, v3, v4;
  logic [3:0]  training_sequence_o;
  logic        scramble_enable_o;

  always #5 clk = ~clk;

  gen1_scramble_ctrl dut (
    .clk_i                  (clk),
    .rst_i                  (rst_i),
    .valid_i                (valid_i),
    .data_i                 (data_i),
    .datak_i                (datak_i),
    .scramble_enable_i      (scramble_enable_i),
    .valid_o                (valid_o),
    .data_o                 (data_o),
    .datak_o                (datak_o),
    .lfsr1_scramble_value_o (v1),
    .lfsr2_scramble_value_o (v2),
    .lfsr3_scramble_value_o (v3),
    .lfsr4_scramble_value_o (v4),
    .training_sequence_o    (training_sequence_o),
    .scramble_enable_o      (scramble_enable_o)
  );

  typedef struct packed {
    logic        v;
    logic [31:0] d;
    logic [3:0]  k;
    logic [31:0] vals;   // {byte3, byte2, byte1, byte0}
    logic [3:0]  ts;
    logic        en;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;

  // Reference model: a keystream generator plus a "symbols since COM" counter.
  logic [15:0] m_lfsr;
  bit          m_win;
  int          m_since_com;
  exp_t        m_last;

  function automatic logic [7:0] rev8(input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = x[7-i];
    return r;
  endfunction

  // Draw 8 keystream bits from the polynomial; first bit lands in [7].
  function automatic logic [7:0] draw8(input logic [15:0] s, output logic [15:0] s_after);
    logic [7:0] v;
    logic       fb;
    for (int i = 0; i < 8; i++) begin
      fb = s[15];
      v[7-i] = fb;
      s = s << 1;
      if (fb) s = s ^ 16'b0000_0000_0011_1001;
    end
    s_after = s;
    return v;
  endfunction

  task automatic model_reset();
    m_lfsr = M_SEED;
    m_win = 1'b0;
    m_since_com = 0;
    m_last = '0;
  endtask

  task automatic model_beat(input logic v, input logic [31:0] d, input logic [3:0] k,
                            input logic en, output exp_t e);
    logic [7:0]  b;
    logic [15:0] nxt;
    if (!v) begin
      e = m_last;
      e.v = 1'b0;
      return;
    end
    e = '0;
    e.v = 1'b1; e.d = d; e.k = k; e.en = en;
    for (int n = 0; n < 4; n++) begin
      b = d[8*n +: 8];
      e.vals[8*n +: 8] = draw8(m_lfsr, nxt);
      if (k[n] && b == S_COM)      m_lfsr = M_SEED;
      else if (!(k[n] && b == S_SKP)) m_lfsr = nxt;
      if (k[n] && b == S_COM) begin
        m_win = 1'b1; m_since_com = 0;
      end else if (m_win) begin
        if (k[n] && b != S_PAD) m_win = 1'b0;
        else begin
          e.ts[n] = 1'b1;
          m_since_com++;
          if (m_since_com == 15) m_win = 1'b0;
        end
      end
    end
    m_last = e;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  // Called just after a posedge; inputs apply to the next edge.
  task automatic step(input logic v, input logic [31:0] d, input logic [3:0] k, input logic en);
    exp_t e;
    valid_i = v; data_i = d; datak_i = k; scramble_enable_i = en;
    model_beat(v, d, k, en, e);
    @(posedge clk);
    sb.push_back(e);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, {31'd0, valid_o}, 32'd0);
    chk({tag, "_data"}, data_o, 32'd0);
    chk({tag, "_k_ts_en"}, {23'd0, datak_o, training_sequence_o, scramble_enable_o}, 32'd0);
    chk({tag, "_vals"}, {v4, v3, v2, v1}, 32'd0);
  endtask

  task automatic do_reset();
    rst_i = 1'b1; valid_i = 1'b0;
    #1;
    sb.delete();
    model_reset();
    chk_zero("reset_mid");
    @(posedge clk); #1;
    rst_i = 1'b0;
  endtask

  task automatic chk_seed_stream(input string tag);
    chk({tag, "_ks"}, {rev8(v1), rev8(v2), rev8(v3), rev8(v4)}, 32'hFF17C014);
    chk({tag, "_ts"}, {28'd0, training_sequence_o}, 32'd0);
  endtask

  // Scoreboard monitor: one expected entry per clock while driving.
  always @(negedge clk) begin
    exp_t e, a;
    if (mon_en && !rst_i && sb.size() > 0) begin
      e = sb.pop_front();
      a = {valid_o, data_o, datak_o, v4, v3, v2, v1, training_sequence_o, scramble_enable_o};
      n_vec++;
      if (a !== e) begin
        n_err++;
        $display("FAIL beat: got v=%b d=%h k=%h vals=%h ts=%b en=%b, want v=%b d=%h k=%h vals=%h ts=%b en=%b",
                 a.v, a.d, a.k, a.vals, a.ts, a.en, e.v, e.d, e.k, e.vals, e.ts, e.en);
      end
    end
  end

  initial begin
    logic [31:0] d;
    logic [3:0]  k;
    int          r;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_i = 1'b0;
    mon_en = 1'b1;

    // Seed keystream
    step(1, {8'h00, 8'h00, 8'h00, S_COM}, 4'b0001, 1);
    chk("seed_ks", {rev8(v2), rev8(v3), rev8(v4)}, {8'h00, 24'hFF17C0});
    chk("seed_ts", {28'd0, training_sequence_o}, 32'hE);

    // SKP hold
    step(1, {S_SKP, S_SKP, S_SKP, S_COM}, 4'hF, 1);
    chk("skp_ts0", {28'd0, training_sequence_o}, 32'd0);
    step(1, 32'h0, 4'h0, 1);
    chk_seed_stream("skp_hold");

    // TS1 window
    step(1, {8'hFF, S_PAD, S_PAD, S_COM}, 4'b0111, 1);
    chk("ts1_b0", {28'd0, training_sequence_o}, 32'hE);
    for (int i = 1; i <= 3; i++) begin
      step(1, 32'h4A4A4A4A, 4'h0, 1);
      chk("ts1_body", {28'd0, training_sequence_o}, 32'hF);
    end
    step(1, 32'h12345678, 4'h0, 1);
    chk("ts1_after", {28'd0, training_sequence_o}, 32'd0);

    // COM at byte 3
    step(1, {S_COM, 8'h00, 8'h00, 8'h00}, 4'b1000, 1);
    step(1, 32'h0, 4'h0, 1);
    chk("com_b3", {24'd0, rev8(v1)}, 32'hFF);
    chk("com_b3_b1", {24'd0, rev8(v2)}, 32'h17);

    // Stall and enable
    step(1, 32'h0, 4'h0, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 32'hDEADBEEF, 4'h0, 1);
      chk("stall_valid", {31'd0, valid_o}, 32'd0);
    end
    step(1, 32'h0, 4'h0, 1);
    step(1, 32'h0, 4'h0, 0);
    chk("en_off", {31'd0, scramble_enable_o}, 32'd0);
    step(1, 32'h0, 4'h0, 1);
    chk("en_on", {31'd0, scramble_enable_o}, 32'd1);

    // Reset mid-window
    step(1, {8'h00, 8'h00, 8'h00, S_COM}, 4'b0001, 1);
    step(1, 32'h0, 4'h0, 1);
    do_reset();
    step(1, 32'h0, 4'h0, 1);
    chk_seed_stream("rst_mid");

    // Randomized traffic, one random reset partway through
    for (int t = 0; t < 400; t++) begin
      d = '0; k = '0;
      for (int n = 0; n < 4; n++) begin
        r = $urandom_range(0, 99);
        if (r < 8)       begin d[8*n +: 8] = S_COM; k[n] = 1'b1; end
        else if (r < 12) begin d[8*n +: 8] = S_SKP; k[n] = 1'b1; end
        else if (r < 22) begin d[8*n +: 8] = S_PAD; k[n] = 1'b1; end
        else if (r < 25) begin d[8*n +: 8] = S_FTS; k[n] = 1'b1; end
        else             begin d[8*n +: 8] = 8'($urandom); k[n] = 1'b0; end
      end
      if (t == 200) do_reset();
      step(($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0, d, k, 1'($urandom));
    end

    step(0, 32'h0, 4'h0, 0);
    step(0, 32'h0, 4'h0, 0);
    @(negedge clk); #1;
    chk("sb_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
